// File: rtl/if_byte_fetcher_pkg.sv
// Shared constants and types for the IF byte fetcher.
//   RstEnable     : active level of the synchronous reset
//   Grant*        : memory-controller grant encodings (if_or_mem_i)
//   InstWidth     : assembled instruction width
//   ByteWidth     : width of one RAM read
//   fetch_state_t : FETCH (issuing byte reads) / HOLD (instruction offered to decode)
package if_byte_fetcher_pkg;
  localparam logic       RstEnable = 1'b1;
  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantIF   = 2'b01;
  localparam logic [1:0] GrantMEM  = 2'b10;
  localparam int         InstWidth = 32;
  localparam int         ByteWidth = 8;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/if_byte_fetcher.sv
// IF-side fetch unit. Assembles one 32-bit little-endian instruction from
// four byte reads through the shared byte-wide memory controller, then offers
// it to decode under a valid/ready handshake. Branch redirects take effect at
// the next edge and drop all in-flight progress.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   if_request, if_addr : byte-read request and its address
//   if_or_mem_i         : controller grant this cycle (01 IF, 10 MEM, 00 none)
//   cpu_data_i          : read byte, valid the cycle after a granted read
//   branch_i, branch_target_i : redirect from EX
//   inst_o, pc_o, inst_valid_o, inst_ready_i : decode handshake
module if_byte_fetcher
  import if_byte_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 if_request,
  output logic [31:0]          if_addr,
  input  logic [1:0]           if_or_mem_i,
  input  logic [ByteWidth-1:0] cpu_data_i,
  input  logic                 branch_i,
  input  logic [31:0]          branch_target_i,
  output logic [InstWidth-1:0] inst_o,
  output logic [31:0]          pc_o,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i
);

  fetch_state_t         r_state, w_state_n;
  logic [31:0]          r_pc, w_pc_n;
  logic [2:0]           r_req_cnt, w_req_cnt_n;   // bytes granted so far, 0..4
  logic                 r_pend_valid, w_pend_valid_n;
  logic [1:0]           r_pend_idx, w_pend_idx_n;
  logic [InstWidth-1:0] r_buf, w_buf_n;
  logic [InstWidth-1:0] r_inst, w_inst_n;
  logic [31:0]          r_pc_o, w_pc_o_n;
  logic                 r_valid, w_valid_n;
  logic                 w_grant;

  assign if_request = (rst != RstEnable) && (r_state == FETCH) && (r_req_cnt != 3'd4);
  assign if_addr    = r_pc + {29'd0, r_req_cnt};
  assign w_grant    = if_request && (if_or_mem_i == GrantIF);

  assign inst_o       = r_inst;
  assign pc_o         = r_pc_o;
  assign inst_valid_o = r_valid;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_req_cnt    <= 3'd0;
      r_pend_valid <= 1'b0;
      r_pend_idx   <= 2'd0;
      r_buf        <= '0;
      r_inst       <= '0;
      r_pc_o       <= RESET_PC;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_req_cnt    <= w_req_cnt_n;
      r_pend_valid <= w_pend_valid_n;
      r_pend_idx   <= w_pend_idx_n;
      r_buf        <= w_buf_n;
      r_inst       <= w_inst_n;
      r_pc_o       <= w_pc_o_n;
      r_valid      <= w_valid_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_req_cnt_n    = r_req_cnt;
    w_pend_valid_n = r_pend_valid;
    w_pend_idx_n   = r_pend_idx;
    w_buf_n        = r_buf;
    w_inst_n       = r_inst;
    w_pc_o_n       = r_pc_o;
    w_valid_n      = r_valid;

    if (branch_i) begin
      // Redirect: the byte arriving now and any byte granted now are dropped.
      w_pc_n         = branch_target_i;
      w_state_n      = FETCH;
      w_req_cnt_n    = 3'd0;
      w_pend_valid_n = 1'b0;
      w_valid_n      = 1'b0;
    end else begin
      w_pend_valid_n = w_grant;
      if (w_grant) begin
        w_req_cnt_n  = r_req_cnt + 3'd1;
        w_pend_idx_n = r_req_cnt[1:0];
      end

      // Data belongs to last cycle's granted address, so it is taken even
      // when MEM owns the bus this cycle.
      if (r_pend_valid) begin
        w_buf_n[{r_pend_idx, 3'b000} +: ByteWidth] = cpu_data_i;
        if (r_pend_idx == 2'd3) begin
          w_state_n = HOLD;
          w_valid_n = 1'b1;
          w_inst_n  = {cpu_data_i, r_buf[23:0]};
          w_pc_o_n  = r_pc;
        end
      end

      if ((r_state == HOLD) && r_valid && inst_ready_i) begin
        w_pc_n      = r_pc + 32'd4;
        w_req_cnt_n = 3'd0;
        w_state_n   = FETCH;
        w_valid_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_byte_fetcher.sv
// Self-checking bench for if_byte_fetcher. The bench plays the memory
// controller and RAM; a transaction-level model tracks the expected address
// stream, valid timing and assembled instruction.
module tb_if_byte_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_request;
  logic [31:0] if_addr;
  logic [1:0]  if_or_mem_i = 2'b00;
  logic [7:0]  cpu_data_i = 8'h00;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;

  if_byte_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .if_request(if_request), .if_addr(if_addr),
    .if_or_mem_i(if_or_mem_i), .cpu_data_i(cpu_data_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .inst_o(inst_o), .pc_o(pc_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;       // bytes granted for the current instruction
  logic        m_arm = 1'b0;    // last byte granted, valid due at next edge
  logic        m_valid = 1'b0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_pco = 32'h0;
  int          n_grants = 0;

  // controller side: byte granted last cycle
  logic        pend_ok = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [7:0] ram(input logic [31:0] a);
    case (a)
      32'h0: ram = 8'h13;
      32'h1: ram = 8'h05;
      32'h2: ram = 8'h00;
      32'h3: ram = 8'h00;
      default: ram = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5 ^ {a[1:0], a[7:2]};
    endcase
  endfunction

  function automatic logic [31:0] ramword(input logic [31:0] p);
    ramword = {ram(p + 32'd3), ram(p + 32'd2), ram(p + 32'd1), ram(p)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check request side, clock, update model,
  // check registered outputs. Entered and left just after a falling edge.
  task automatic cyc(input logic [1:0] g, input logic br, input logic [31:0] tgt,
                     input logic rdy, input logic r);
    logic m_req, granted, nv;
    logic [31:0] a;
    rst = r; if_or_mem_i = g; branch_i = br; branch_target_i = tgt; inst_ready_i = rdy;
    cpu_data_i = pend_ok ? ram(pend_addr) : 8'($urandom);
    #1;
    m_req = !r && !m_valid && (m_cnt != 4);
    chk("if_request", {31'd0, if_request}, {31'd0, m_req});
    if (m_req) chk("if_addr", if_addr, m_pc + m_cnt);
    a = if_addr;
    granted = if_request && (g == 2'b01);
    @(posedge clk);
    #1;
    pend_ok = granted;
    pend_addr = a;
    if (r) begin
      m_pc = 32'h0; m_cnt = 0; m_arm = 0; m_valid = 0; m_inst = 32'h0; m_pco = 32'h0;
      n_grants = 0;
    end else if (br) begin
      m_pc = tgt; m_cnt = 0; m_arm = 0; m_valid = 0; n_grants = 0;
    end else begin
      nv = m_valid;
      if (m_arm) begin
        nv = 1'b1; m_arm = 1'b0; m_pco = m_pc; m_inst = ramword(m_pc);
      end
      if (granted) begin
        n_grants++;
        m_cnt++;
        if (m_cnt == 4) m_arm = 1'b1;
      end
      if (m_valid && rdy) begin
        nv = 1'b0; m_pc = m_pc + 32'd4; m_cnt = 0; n_grants = 0;
      end
      m_valid = nv;
    end
    chk("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, m_valid});
    if (m_valid || r) begin
      chk("inst_o", inst_o, m_inst);
      chk("pc_o", pc_o, m_pco);
    end
    @(negedge clk);
  endtask

  // Fetch with IF always granted until valid; returns cycles taken.
  task automatic run_to_valid(input int maxc, output int n);
    n = 0;
    while (!inst_valid_o && n < maxc) begin
      cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
      n++;
    end
    chk("valid_within_bound", {31'd0, inst_valid_o}, 32'd1);
  endtask

  initial begin
    int n, k;
    @(negedge clk);
    // reset
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);

    // uncontended fetch from 0
    run_to_valid(20, n);
    chk("latency_plain", n, 5);
    chk("inst_0", inst_o, 32'h0000_0513);
    chk("pc_0", pc_o, 32'h0);
    chk("grants_plain", n_grants, 4);

    // held for 3 cycles, then accepted; next fetch at 4
    for (int i = 0; i < 3; i++) cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hold_inst", inst_o, 32'h0000_0513);
    cyc(2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
    run_to_valid(20, n);
    chk("pc_4", pc_o, 32'h4);
    chk("inst_4", inst_o, ramword(32'h4));

    // stall: MEM owns the bus for 2 cycles after byte 1 is granted
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
    run_to_valid(20, n);
    chk("latency_stall", n + 4, 7);
    chk("inst_stall", inst_o, 32'h0000_0513);
    chk("grants_stall", n_grants, 4);

    // accept, then branch in the cycle after byte 1 was granted
    cyc(2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 32'h100, 1'b0, 1'b0);
    run_to_valid(20, n);
    chk("pc_branch", pc_o, 32'h100);
    chk("inst_branch", inst_o, ramword(32'h100));

    // branch and accept in the same cycle
    cyc(2'b01, 1'b1, 32'h200, 1'b1, 1'b0);
    run_to_valid(20, n);
    chk("pc_branch_accept", pc_o, 32'h200);

    // reset mid-fetch
    cyc(2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
    run_to_valid(20, n);
    chk("pc_after_rst", pc_o, 32'h0);
    chk("latency_after_rst", n, 5);

    // address wrap
    cyc(2'b01, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run_to_valid(20, n);
    chk("pc_wrap", pc_o, 32'hFFFF_FFFC);
    cyc(2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
    run_to_valid(20, n);
    chk("pc_after_wrap", pc_o, 32'h0);

    // randomized interleaving of grants, backpressure and redirects
    for (int i = 0; i < 600; i++) begin
      logic [1:0] g;
      k = $urandom_range(0, 9);
      g = (k < 6) ? 2'b01 : (k < 8) ? 2'b10 : 2'b00;
      cyc(g, ($urandom_range(0, 39) == 0), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_byte_fetcher.md
Name: if_byte_fetcher

Overview:
IF-side fetch unit that sits directly upstream of the byte-wide memory controller. It assembles one 32-bit little-endian instruction from four single-byte reads. It holds the instruction under a valid/ready handshake to the decode stage. It tolerates losing the RAM bus to MEM loads and stores, and it redirects immediately on branch/jump.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
if_request  out  1  byte-read request to the memory controller.
if_addr  out  32  byte address of the current request.
if_or_mem_i  in  2  controller grant this cycle: 01 = IF, 10 = MEM, 00 = none.
cpu_data_i  in  8  RAM read byte from the controller; valid one cycle after a granted read.
branch_i  in  1  redirect request from EX.
branch_target_i  in  32  redirect PC.
inst_o  out  32  assembled instruction.
pc_o  out  32  PC of inst_o.
inst_valid_o  out  1  inst_o/pc_o valid.
inst_ready_i  in  1  decode accepts the instruction this cycle.

Behaviour:
- State:
  - pc (32b);
  - state ∈ {FETCH, HOLD};
  - req_cnt (3b, 0..4): bytes issued and granted;
  - pend_valid/pend_idx (1b/2b): granted byte whose data arrives next cycle;
  - buf (32b) assembly register.
- Reset (rst=1 at clock edge):
  - pc=RESET_PC, state=FETCH, req_cnt=0, pend_valid=0, buf=0.
  - Outputs: inst_o=0, pc_o=RESET_PC, inst_valid_o=0, if_request=0 during the reset cycle.
- Request outputs (combinational from registers):
  - if_request = !rst && state==FETCH && req_cnt!=4.
  - if_addr = pc + req_cnt, 32-bit modular, wraps past 0xFFFFFFFF.
- Grant:
  - A cycle with if_request=1 and if_or_mem_i==2'b01 is a grant. On a grant: req_cnt++, pend_valid<=1, pend_idx<=req_cnt[1:0].
  - Without a grant, req_cnt holds and the same address is re-presented next cycle.
  - No address is ever skipped or issued twice, whatever the MEM interleaving.
- Capture:
  - When pend_valid=1, buf[8*pend_idx +: 8] <= cpu_data_i. The data is taken even if MEM owns the bus this cycle, because the RAM returns the byte addressed in the previous cycle.
  - If no new grant occurs this cycle, pend_valid<=0.
  - Capture of idx 3: state<=HOLD, inst_valid_o<=1, inst_o<={byte3,byte2,byte1,byte0}, pc_o<=pc.
- Latency: uncontended fetch takes 5 cycles from the first request to inst_valid_o=1. Each cycle the grant is withheld adds 1 cycle.
- HOLD:
  - if_request=0; inst_o, pc_o and inst_valid_o are held stable.
  - On inst_valid_o && inst_ready_i: pc<=pc+4, req_cnt<=0, state<=FETCH, inst_valid_o<=0.
  - The first request for the next instruction appears in the following cycle.
- Branch (highest priority after rst), when branch_i=1 at a clock edge:
  - pc<=branch_target_i, state<=FETCH, req_cnt<=0, pend_valid<=0, inst_valid_o<=0.
  - Any byte granted in the branch cycle is discarded; it must not write buf.
  - A simultaneous handshake is ignored, i.e. the branch wins over pc+4.
  - A request that is combinationally visible during the branch cycle is allowed (harmless read).
- Handshake boundary: inst_ready_i while inst_valid_o=0 has no effect.
- Reset mid-fetch: all progress is dropped and the fetch restarts at RESET_PC.
- No alignment check on pc.

Decomposition:
- Shared defines/package:
  - RstEnable (1'b1);
  - grant encodings GrantNone=2'b00, GrantIF=2'b01, GrantMEM=2'b10;
  - InstWidth=32, ByteWidth=8;
  - FETCH/HOLD state encodings.
- Single module; no sub-module is warranted. Byte-lane insertion is an indexed part-select.

Test Plan:
- Reset, then RAM[0..3]=13 05 00 00, grant always 01 → if_addr 0,1,2,3 on consecutive cycles; inst_o=0x00000513, pc_o=0, inst_valid_o=1 five cycles after the first request.
- Same as above, but grant=10 for 2 cycles after byte 1 is granted → if_addr stays 2 during the stall; inst_o=0x00000513 two cycles later; exactly four grants observed.
- inst_ready_i=0 for 3 cycles after valid → outputs stable and if_request=0; on the accept cycle the next fetch starts at pc 4 with addresses 4..7.
- branch_i=1 with target 0x100 in the cycle after byte 1 was granted → that byte is not captured; fetch restarts at 0x100..0x103; inst_o carries only bytes from 0x100 region; pc_o=0x100.
- branch_i and accept in the same cycle → next pc is the branch target, not pc+4. rst asserted mid-fetch → if_request=0 the next cycle, then the fetch restarts at RESET_PC.
- pc=0xFFFFFFFC → addresses FFFFFFFC..FFFFFFFF; after accept, next fetch addresses 0..3.
